// File: rtl/cfg_serial_tx_if.sv
// Signal bundle between FPGA control logic / backend pins and cfg_serial_tx.
// master = the transmitter itself, slave = whoever drives start/ready and watches the link.
interface cfg_serial_tx_if #(
    parameter int FRAME_W = 5
);
    logic               i_start;
    logic [FRAME_W-1:0] i_cfg_word;
    logic               i_ready;
    logic               o_resetbAll;
    logic               o_sclk;
    logic               o_sdout;
    logic               o_busy;
    logic               o_done;
    logic               o_timeout;
    // Encoded FSM state: 0 IDLE, 1 RST_HOLD, 2 SHIFT, 3 WAIT_READY.
    logic [1:0]         dbg_state;

    modport master (
        input  i_start, i_cfg_word, i_ready,
        output o_resetbAll, o_sclk, o_sdout, o_busy, o_done, o_timeout, dbg_state
    );

    modport slave (
        output i_start, i_cfg_word, i_ready,
        input  o_resetbAll, o_sclk, o_sdout, o_busy, o_done, o_timeout, dbg_state
    );
endinterface

// File: rtl/cfg_serial_tx.sv
// Backend configuration initiator: reset pulse, MSB-first serial gain frame, ready handshake.
// Handshake: i_start is a one-cycle request honoured only in IDLE; o_done / o_timeout report the outcome.
module cfg_serial_tx #(
    parameter int CLK_DIV       = 2,
    parameter int FRAME_W       = 5,
    parameter int RST_CYCLES    = 4,
    parameter int READY_TIMEOUT = 64
) (
    input  logic             i_mainclk,
    input  logic             i_reset,
    cfg_serial_tx_if.master  bus
);
    localparam int MAX_A = (CLK_DIV > RST_CYCLES) ? CLK_DIV : RST_CYCLES;
    localparam int MAX_B = (READY_TIMEOUT > FRAME_W) ? READY_TIMEOUT : FRAME_W;
    localparam int MAX_V = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = $clog2(MAX_V + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RST_HOLD   = 2'd1,
        SHIFT      = 2'd2,
        WAIT_READY = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_n;
    logic               phase, phase_n;
    logic [FRAME_W-1:0] shreg, shreg_n;
    logic [FRAME_W-1:0] sh_left;
    logic               sclk, sclk_n;
    logic               sdout, sdout_n;
    logic               resetb, resetb_n;
    logic               done, done_n;
    logic               timeout, timeout_n;

    assign sh_left = shreg << 1;

    always_ff @(posedge i_mainclk) begin
        if (i_reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            phase   <= 1'b0;
            shreg   <= '0;
            sclk    <= 1'b0;
            sdout   <= 1'b0;
            resetb  <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_cnt_n;
            phase   <= phase_n;
            shreg   <= shreg_n;
            sclk    <= sclk_n;
            sdout   <= sdout_n;
            resetb  <= resetb_n;
            done    <= done_n;
            timeout <= timeout_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        phase_n   = phase;
        shreg_n   = shreg;
        sclk_n    = sclk;
        sdout_n   = sdout;
        done_n    = 1'b0;
        timeout_n = timeout;

        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    shreg_n   = bus.i_cfg_word;
                    timeout_n = 1'b0;
                    cnt_n     = '0;
                    state_n   = RST_HOLD;
                end
            end
            RST_HOLD: begin
                if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                    // Present the MSB together with the first low sclk phase.
                    state_n   = SHIFT;
                    cnt_n     = '0;
                    bit_cnt_n = '0;
                    phase_n   = 1'b0;
                    sclk_n    = 1'b0;
                    sdout_n   = shreg[FRAME_W-1];
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(CLK_DIV - 1)) begin
                    cnt_n = '0;
                    if (!phase) begin
                        phase_n = 1'b1;
                        sclk_n  = 1'b1;
                    end else begin
                        phase_n = 1'b0;
                        sclk_n  = 1'b0;
                        if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
                            state_n = WAIT_READY;
                            sdout_n = 1'b0;
                        end else begin
                            bit_cnt_n = bit_cnt + CNT_W'(1);
                            shreg_n   = sh_left;
                            sdout_n   = sh_left[FRAME_W-1];
                        end
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            WAIT_READY: begin
                // Ready is checked before the limit so a last-cycle ready still succeeds.
                if (bus.i_ready) begin
                    done_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (cnt == CNT_W'(READY_TIMEOUT - 1)) begin
                    timeout_n = 1'b1;
                    cnt_n     = '0;
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        resetb_n = (state_n != RST_HOLD);
    end

    assign bus.o_resetbAll = resetb;
    assign bus.o_sclk      = sclk;
    assign bus.o_sdout     = sdout;
    assign bus.o_busy      = (state != IDLE);
    assign bus.o_done      = done;
    assign bus.o_timeout   = timeout;
    assign bus.dbg_state   = state;
endmodule

// File: tb/tb_cfg_serial_tx.sv
// Directed bench for cfg_serial_tx: cycle positions counted from the edge that samples i_start (E0).
module tb_cfg_serial_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    cfg_serial_tx_if #(.FRAME_W(5)) bus ();

    cfg_serial_tx dut (
        .i_mainclk (clk),
        .i_reset   (rst),
        .bus       (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Per-transaction observations, indexed by k = cycles after E0.
    int       low_cnt, low_first, hi_cnt, done_cnt, done_pos, busy_fall, to_first, sd_bad;
    int       to_at0, st_at0;
    int       rise_q[$];
    logic [4:0] bits;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [4:0] word, input int ready_at,
                           input logic [4:0] alt_word, input int alt_at);
        logic prev_sclk, prev_sdout;
        bus.i_cfg_word = word;
        bus.i_start    = 1'b1;
        step();
        bus.i_start = 1'b0;
        low_cnt = 0; low_first = -1; hi_cnt = 0; done_cnt = 0; done_pos = -1;
        busy_fall = -1; to_first = -1; sd_bad = 0; bits = '0;
        rise_q.delete();
        prev_sclk = 1'b0;
        prev_sdout = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (k == 0) begin
                st_at0 = int'(bus.dbg_state);
                to_at0 = int'(bus.o_timeout);
            end
            if (!bus.o_resetbAll) begin
                low_cnt++;
                if (low_first < 0) low_first = k;
            end
            if (bus.o_sclk) hi_cnt++;
            if (bus.o_sclk && !prev_sclk) begin
                rise_q.push_back(k);
                bits = {bits[3:0], bus.o_sdout};
            end
            if (bus.o_sclk && prev_sclk && (bus.o_sdout != prev_sdout)) sd_bad++;
            if (bus.o_done) begin
                done_cnt++;
                done_pos = k;
            end
            if (!bus.o_busy && busy_fall < 0) busy_fall = k;
            if (bus.o_timeout && to_first < 0) to_first = k;
            prev_sclk  = bus.o_sclk;
            prev_sdout = bus.o_sdout;
            bus.i_ready    = (ready_at > 0) && (k + 1 >= ready_at);
            bus.i_start    = (alt_at > 0) && (k + 1 == alt_at);
            bus.i_cfg_word = ((alt_at > 0) && (k + 1 == alt_at)) ? alt_word : word;
            step();
        end
        bus.i_ready = 1'b0;
        bus.i_start = 1'b0;
        step();
    endtask

    // Shared frame-shape checks: reset pulse E0..E3, rises at 6,10,14,18,22, 10 high samples.
    task automatic check_frame(input string tag, input logic [4:0] exp_bits);
        check({tag, "_rst_low_cnt"}, low_cnt, 4);
        check({tag, "_rst_low_first"}, low_first, 0);
        check({tag, "_state_at_e0"}, st_at0, 1);
        check({tag, "_rise_cnt"}, rise_q.size(), 5);
        if (rise_q.size() > 0) check({tag, "_first_rise"}, rise_q[0], 6);
        for (int i = 1; i < rise_q.size(); i++)
            check({tag, "_sclk_period"}, rise_q[i] - rise_q[i-1], 4);
        check({tag, "_sclk_hi_cnt"}, hi_cnt, 10);
        check({tag, "_sdout_stable"}, sd_bad, 0);
        check({tag, "_bits"}, bits, exp_bits);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_start    = 1'b0;
        bus.i_cfg_word = '0;
        bus.i_ready    = 1'b0;
        rst = 1'b1;
        step(); step(); step();
        check("rst_resetb", bus.o_resetbAll, 0);
        check("rst_sclk", bus.o_sclk, 0);
        check("rst_sdout", bus.o_sdout, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_done", bus.o_done, 0);
        check("rst_timeout", bus.o_timeout, 0);
        check("rst_state", bus.dbg_state, 0);
        rst = 1'b0;
        step();
        check("post_rst_resetb", bus.o_resetbAll, 1);
        for (int i = 0; i < 10; i++) step();
        check("idle_resetb", bus.o_resetbAll, 1);
        check("idle_sclk", bus.o_sclk, 0);
        check("idle_sdout", bus.o_sdout, 0);
        check("idle_busy", bus.o_busy, 0);
        check("idle_done", bus.o_done, 0);

        // Nominal frame 10_011, ready sampled 3 cycles after SHIFT ends (E27).
        run_txn(5'b10011, 27, 5'b00000, 0);
        check_frame("f1", 5'b10011);
        check("f1_done_cnt", done_cnt, 1);
        check("f1_done_pos", done_pos, 27);
        check("f1_busy_fall", busy_fall, 27);
        check("f1_timeout", to_first, -1);

        // Ready never arrives: timeout after 64 WAIT_READY cycles (E25..E88).
        run_txn(5'b01010, 0, 5'b00000, 0);
        check_frame("to", 5'b01010);
        check("to_done_cnt", done_cnt, 0);
        check("to_timeout_pos", to_first, 88);
        check("to_busy_fall", busy_fall, 88);
        check("to_sticky", bus.o_timeout, 1);

        // Ready high from the start: ignored until WAIT_READY, then done at E25; start clears timeout.
        run_txn(5'b00101, 1, 5'b00000, 0);
        check_frame("clr", 5'b00101);
        check("clr_timeout_at_e0", to_at0, 0);
        check("clr_timeout", to_first, -1);
        check("clr_done_cnt", done_cnt, 1);
        check("clr_done_pos", done_pos, 25);

        // A second start during SHIFT with another word must not disturb the frame.
        run_txn(5'b01101, 30, 5'b10010, 10);
        check_frame("ign", 5'b01101);
        check("ign_done_cnt", done_cnt, 1);
        check("ign_done_pos", done_pos, 30);

        // Reset after two bits (asserted for edge E12) aborts everything.
        bus.i_cfg_word = 5'b11010;
        bus.i_start    = 1'b1;
        step();
        bus.i_start = 1'b0;
        for (int i = 0; i < 11; i++) step();
        check("mid_sdout_before", bus.o_sdout, 1);
        check("mid_sclk_before", bus.o_sclk, 1);
        rst = 1'b1;
        step();
        check("mid_resetb", bus.o_resetbAll, 0);
        check("mid_sclk", bus.o_sclk, 0);
        check("mid_sdout", bus.o_sdout, 0);
        check("mid_busy", bus.o_busy, 0);
        check("mid_done", bus.o_done, 0);
        check("mid_state", bus.dbg_state, 0);
        rst = 1'b0;
        step();
        check("mid_post_resetb", bus.o_resetbAll, 1);
        step();

        run_txn(5'b11010, 30, 5'b00000, 0);
        check_frame("rerun", 5'b11010);
        check("rerun_done_pos", done_pos, 30);

        // Ready arrives exactly on the limit cycle: success wins.
        run_txn(5'b11111, 88, 5'b00000, 0);
        check_frame("edge", 5'b11111);
        check("edge_done_cnt", done_cnt, 1);
        check("edge_done_pos", done_pos, 88);
        check("edge_timeout", to_first, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
